// File: rtl/cbus_sram_responder.sv
// Cache-bus memory responder: serves single and burst reads/writes from an internal
// word array, with a programmable first-beat latency and inter-beat gap.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_sram_responder #(
  parameter int MEM_WORDS_LOG2 = 14,
  parameter int FIRST_LATENCY  = 2,
  parameter int BEAT_GAP       = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  cbus_pkg::cbus_req_t  creq,
  output cbus_pkg::cbus_resp_t cresp
);

  localparam int AW      = MEM_WORDS_LOG2;
  localparam int DLY_MAX = (FIRST_LATENCY > BEAT_GAP) ? FIRST_LATENCY : BEAT_GAP;
  localparam int DW      = (DLY_MAX > 2) ? $clog2(DLY_MAX) : 1;

  localparam logic [DW-1:0] FIRST_LOAD = DW'((FIRST_LATENCY > 0) ? FIRST_LATENCY - 1 : 0);
  localparam logic [DW-1:0] GAP_LOAD   = DW'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_GAP,
    S_TURN
  } state_t;

  state_t          state, state_d;
  logic [3:0]      beat_cnt, beat_d;
  logic [DW-1:0]   dly_cnt, dly_d;
  logic [AW-1:0]   base, base_d;
  logic [3:0]      len_q, len_d;
  logic            wr_q, wr_d;

  logic [31:0]     mem [2**AW];
  logic [AW-1:0]   cur_idx;
  logic            in_beat;
  logic            is_last;

  // size and the address bits outside the word index never affect behaviour.
  logic            unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};

  assign cur_idx = base + AW'(beat_cnt);
  assign in_beat = (state == S_BEAT);
  assign is_last = (beat_cnt == len_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      dly_cnt  <= '0;
      base     <= '0;
      len_q    <= '0;
      wr_q     <= 1'b0;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_d;
      dly_cnt  <= dly_d;
      base     <= base_d;
      len_q    <= len_d;
      wr_q     <= wr_d;
    end
  end

  // A dropped valid in any busy state is a protocol abort back to IDLE.
  always_comb begin
    state_d = state;
    beat_d  = beat_cnt;
    dly_d   = dly_cnt;
    base_d  = base;
    len_d   = len_q;
    wr_d    = wr_q;
    case (state)
      S_IDLE: begin
        if (creq.valid) begin
          base_d = creq.addr[AW+1:2];
          len_d  = creq.len;
          wr_d   = creq.is_write;
          beat_d = '0;
          if (FIRST_LATENCY > 0) begin
            state_d = S_WAIT;
            dly_d   = FIRST_LOAD;
          end else begin
            state_d = S_BEAT;
          end
        end
      end
      S_WAIT, S_GAP: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else if (dly_cnt == '0) begin
          state_d = S_BEAT;
        end else begin
          dly_d = dly_cnt - 1'b1;
        end
      end
      S_BEAT: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else if (is_last) begin
          state_d = S_TURN;
        end else begin
          beat_d = beat_cnt + 1'b1;
          if (BEAT_GAP > 0) begin
            state_d = S_GAP;
            dly_d   = GAP_LOAD;
          end
        end
      end
      S_TURN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cresp       = '0;
    cresp.ready = in_beat;
    cresp.last  = in_beat && is_last;
    if (in_beat && !wr_q) begin
      cresp.data = mem[cur_idx];
    end
  end

  // Array is deliberately not reset; writes are byte-masked by strobe only.
  always_ff @(posedge clk) begin
    if (in_beat && wr_q && creq.valid) begin
      for (int i = 0; i < 4; i++) begin
        if (creq.strobe[i]) begin
          mem[cur_idx][8*i +: 8] <= creq.data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/cbus_sram_responder.md
Name: cbus_sram_responder

Overview:
- Cache-bus (cbus) responder: the memory-side end of the `cbus_req_t`/`cbus_resp_t` interface that the core's ICache, DCache, uncached converter and arbiter drive as initiators.
- Serves single-beat and burst reads and writes from an internal word-addressed array.
- Has programmable first-beat latency and inter-beat gaps.
- Used as the SoC-less memory model behind the top-level `oreq`/`oresp`, and as the bench target for cache and arbiter verification.

Parameters:
- MEM_WORDS_LOG2, 14, log2 of array depth in 32-bit words; address index = addr[MEM_WORDS_LOG2+1:2], upper bits ignored (aliasing wrap).
- FIRST_LATENCY, 2, idle cycles between request acceptance and first beat; 0 allowed.
- BEAT_GAP, 0, idle cycles (ready=0) inserted between consecutive beats of one burst.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- creq  input  cbus_req_t  request: valid, is_write, size[2:0], addr[31:0], strobe[3:0], data[31:0], len[3:0] (beats-1).
- cresp  output  cbus_resp_t  response: ready, last, data[31:0].

Behaviour:
- Reset (resetn=0, asynchronous):
  - State forced to IDLE; beat and delay counters cleared.
  - cresp.ready=0, cresp.last=0, cresp.data=0 immediately.
  - Array contents are not reset.
- Request handshake, as followed by all cbus initiators:
  - Initiator holds valid, is_write, addr, len, size constant until the beat with ready&last.
  - Each cycle with ready=1 is exactly one beat.
  - For writes the initiator presents the next data/strobe after each ready beat.
- States:
  - IDLE: ready=0. On creq.valid, latch word index base=addr index, len, is_write; clear beat_cnt. Go to WAIT if FIRST_LATENCY>0 (delay counter loaded with FIRST_LATENCY-1), else BEAT.
  - WAIT: ready=0; counter decrements; at 0 go to BEAT.
  - BEAT: ready=1 for exactly one cycle.
    - Word index cur = (base + beat_cnt) mod 2^MEM_WORDS_LOG2; incrementing, no critical-word wrap within the line.
    - Read: cresp.data = mem[cur], combinational from array.
    - Write: at this edge, byte i of mem[cur] <= creq.data byte i where creq.strobe[i]=1; other bytes keep their value. cresp.data=0.
    - cresp.last = (beat_cnt == latched len).
    - Not last: beat_cnt++; go to GAP if BEAT_GAP>0 (counter = BEAT_GAP-1), else stay in BEAT.
    - Last: go to TURN.
  - GAP: ready=0; counter decrements; at 0 go to BEAT.
  - TURN: ready=0 for one cycle, then IDLE. Back-to-back requests therefore start no earlier than 2 cycles after the last beat; valid held high through TURN is treated as a new request in IDLE.
- size: not used for data selection. Reads always return the full aligned word; writes are governed by strobe alone.
- Protocol violation (valid drops in WAIT/BEAT/GAP): abort to IDLE next cycle, ready=0; any beats already written stay committed.
- Latency: with FIRST_LATENCY=L and BEAT_GAP=G, the first beat occurs L+1 cycles after the valid cycle accepted in IDLE. Burst of N beats completes L+1+(N-1)(G+1) cycles after acceptance.
- Reset asserted mid-burst: immediate return to IDLE, outputs 0; partially written burst not rolled back.
- cresp.last is never 1 while ready=0.

Test Plan:
- Single read, L=2, G=0: preload mem[0x10]=0xDEADBEEF; valid, addr=0x0000_0040, len=0 at cycle 0 -> ready=1, last=1, data=0xDEADBEEF at cycle 3 only; ready=0 cycles 4–5.
- 16-beat read burst, L=0: addr=0x100, len=15, mem[0x40+i]=i -> ready=1 cycles 1–16 with data 0..15; last=1 only at cycle 16.
- Strobed write: mem[0x20]=0x11223344; write addr=0x80, len=0, strobe=4'b0101, data=0xAABBCCDD -> mem[0x20]=0x11BB33DD after beat; a follow-up read returns the same value.
- 4-beat write with G=2: addr=0x200, len=3, data 0xA0..0xA3 -> ready pulses spaced 3 cycles apart; mem[0x80..0x83]=0xA0..0xA3; last on 4th pulse.
- Address alias, MEM_WORDS_LOG2=4: read addr=0x3C, len=3 -> beats return mem[15], mem[0], mem[1], mem[2].
- Reset/abort: resetn low during beat 2 of an 8-beat read -> ready/last/data=0 asynchronously; after release, a new len=0 read completes normally. Separately, dropping valid in WAIT -> IDLE, no ready pulse.
